mem_arbiter: RTL and testbench

- N-master to one-memory arbiter for the next-generation SOPC; replaces point-to-point CPU to ROM/RAM wiring.
- Masters are instruction fetch, data port, debug/DMA, and so on. Each uses a ce/we/addr/sel/data request with a one-cycle ready pulse.
- Serialises requests onto a single ack-based memory port, with a per-transaction timeout and error flag.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_arb_select.sv | 30 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizing helpers for the mem_arbiter slice.
// FSM encodings plus width functions for the timeout counter and grant index.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wide enough to hold TIMEOUT itself.
    function automatic int timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of master request/response and memory-port signals for mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the attached agents.
interface mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]            m_ce_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i;
    logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel_i;
    logic [NUM_MASTERS*DATA_W-1:0]     m_wdata_i;
    logic [DATA_W-1:0]                 m_rdata_o;
    logic [NUM_MASTERS-1:0]            m_ready_o;
    logic                              m_err_o;
    logic                              mem_ce_o;
    logic                              mem_we_o;
    logic [ADDR_W-1:0]                 mem_addr_o;
    logic [DATA_W/8-1:0]               mem_sel_o;
    logic [DATA_W-1:0]                 mem_data_o;
    logic [DATA_W-1:0]                 mem_data_i;
    logic                              mem_ack_i;

    // Handshake: a master holds ce/we/addr/sel/wdata stable until its one-cycle
    // m_ready_o pulse; the memory answers a held mem_ce_o with a one-cycle mem_ack_i.
    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i, mem_data_i, mem_ack_i,
        output m_rdata_o, m_ready_o, m_err_o,
        output mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
    );

    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_wdata_i, mem_data_i, mem_ack_i,
        input  m_rdata_o, m_ready_o, m_err_o,
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o
    );
endinterface

// File: rtl/mem_arbiter_arb_select.sv
// Combinational request picker: scans the request vector starting at ptr and
// returns the first requester as one-hot and index (ptr = 0 gives fixed priority).
module arb_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any       = 1'b1;
                onehot[k] = 1'b1;
                idx       = IDX_W'(k);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// N-master to single ack-based memory arbiter with per-transaction timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output state_t        state_dbg
);
    localparam int TW = timer_w(TIMEOUT);
    localparam int IW = idx_w(NUM_MASTERS);
    localparam int SW = DATA_W / 8;

    state_t                 state, state_nx;
    logic [TW-1:0]          timer;
    logic [IW-1:0]          grant, ptr, win_idx;
    logic [NUM_MASTERS-1:0] win_oh;
    logic                   win_any;
    logic                   we_r, err_r, dropped;
    logic [ADDR_W-1:0]      addr_r;
    logic [SW-1:0]          sel_r;
    logic [DATA_W-1:0]      wdata_r, rdata_r;
    logic                   timed_out;

    assign timed_out = (timer == TW'(TIMEOUT));

    arb_select #(.N(NUM_MASTERS), .IDX_W(IW)) u_sel (
        .req    (bus.m_ce_i),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

`ifdef MEM_ARB_RR_EN
    // Search resumes just past the master served last.
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (state == RESP)
            ptr <= (grant == IW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_any) state_nx = BUSY;
            BUSY:    if (bus.mem_ack_i || timed_out) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= '0;
            timer   <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            sel_r   <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            dropped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (win_any) begin
                        grant   <= win_idx;
                        we_r    <= |(bus.m_we_i & win_oh);
                        addr_r  <= bus.m_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                        sel_r   <= bus.m_sel_i[int'(win_idx)*SW +: SW];
                        wdata_r <= bus.m_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
                        dropped <= 1'b0;
                    end
                end
                BUSY: begin
                    // An abandoned request still finishes at memory, silently.
                    if (!bus.m_ce_i[grant]) dropped <= 1'b1;
                    if (bus.mem_ack_i) begin
                        rdata_r <= bus.mem_data_i;
                        err_r   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_r <= '0;
                        err_r   <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

    always_comb begin
        bus.mem_ce_o   = 1'b0;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = '0;
        bus.mem_sel_o  = '0;
        bus.mem_data_o = '0;
        bus.m_ready_o  = '0;
        if (state == BUSY) begin
            bus.mem_ce_o   = 1'b1;
            bus.mem_we_o   = we_r;
            bus.mem_addr_o = addr_r;
            bus.mem_sel_o  = sel_r;
            bus.mem_data_o = wdata_r;
        end
        if (state == RESP && !dropped) bus.m_ready_o[grant] = 1'b1;
    end

    assign bus.m_rdata_o = rdata_r;
    assign bus.m_err_o   = err_r;
    assign state_dbg     = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two masters, TIMEOUT=4, hand-computed expectations
// checked with immediate assertions along one linear sequence of steps.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic   clk;
    logic   rst;
    state_t state_dbg;
    int     total;
    int     bad;

    mem_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic set_req(input int m, input logic ce, input logic we,
                           input logic [AW-1:0] addr, input logic [DW/8-1:0] sel,
                           input logic [DW-1:0] wdata);
        bus.m_ce_i[m]                   = ce;
        bus.m_we_i[m]                   = we;
        bus.m_addr_i[m*AW +: AW]        = addr;
        bus.m_sel_i[m*(DW/8) +: (DW/8)] = sel;
        bus.m_wdata_i[m*DW +: DW]       = wdata;
    endtask

    task automatic set_mem(input logic ack, input logic [DW-1:0] data);
        bus.mem_ack_i  = ack;
        bus.mem_data_i = data;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the contention run
    logic [NM-1:0] exp_q[$];
    logic [NM-1:0] got_q[$];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.m_ce_i = '0; bus.m_we_i = '0; bus.m_addr_i = '0;
        bus.m_sel_i = '0; bus.m_wdata_i = '0;
        set_mem(1'b0, '0);
        tick(); tick();

        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_mem_ce", 64'(bus.mem_ce_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("rst_ready", 64'(bus.m_ready_o), 64'd0);
        check("rst_rdata", 64'(bus.m_rdata_o), 64'd0);
        check("rst_err", 64'(bus.m_err_o), 64'd0);
        rst = 1'b0;
        tick();

        // Single read, ack in the first BUSY cycle
        set_req(0, 1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
        tick();
        check("rd_mem_ce", 64'(bus.mem_ce_o), 64'd1);
        check("rd_mem_addr", 64'(bus.mem_addr_o), 64'h40);
        check("rd_mem_we", 64'(bus.mem_we_o), 64'd0);
        check("rd_ready_early", 64'(bus.m_ready_o), 64'd0);
        set_mem(1'b1, 32'hDEAD_BEEF);
        tick();
        set_mem(1'b0, 32'h0);
        check("rd_ready", 64'(bus.m_ready_o), 64'b01);
        check("rd_rdata", 64'(bus.m_rdata_o), 64'hDEAD_BEEF);
        check("rd_err", 64'(bus.m_err_o), 64'd0);
        check("rd_mem_ce_drop", 64'(bus.mem_ce_o), 64'd0);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        check("rd_ready_once", 64'(bus.m_ready_o), 64'd0);
        check("rd_rdata_hold", 64'(bus.m_rdata_o), 64'hDEAD_BEEF);

        // Byte write from master 1 with a 3-cycle ack latency
        set_req(1, 1'b1, 1'b1, 32'h0000_0100, 4'b0010, 32'h0000_AB00);
        tick();
        for (int c = 1; c <= 3; c++) begin
            check("wr_mem_we", 64'(bus.mem_we_o), 64'd1);
            check("wr_mem_sel", 64'(bus.mem_sel_o), 64'b0010);
            check("wr_ready_early", 64'(bus.m_ready_o), 64'd0);
            if (c == 3) set_mem(1'b1, 32'h0000_0055);
            tick();
        end
        set_mem(1'b0, 32'h0);
        check("wr_ready", 64'(bus.m_ready_o), 64'b10);
        check("wr_err", 64'(bus.m_err_o), 64'd0);
        set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        // Timeout: no ack, ready six cycles after the request with err set
        set_req(0, 1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            check("to_ready_early", 64'(bus.m_ready_o), 64'd0);
            check("to_mem_ce", 64'(bus.mem_ce_o), 64'd1);
            tick();
        end
        check("to_ready", 64'(bus.m_ready_o), 64'b01);
        check("to_err", 64'(bus.m_err_o), 64'd1);
        check("to_rdata", 64'(bus.m_rdata_o), 64'd0);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        check("to_err_hold", 64'(bus.m_err_o), 64'd1);

        // Next request: ack lands in the same cycle the timer hits TIMEOUT
        set_req(0, 1'b1, 1'b0, 32'h0000_0084, 4'hF, 32'h0);
        tick();
        tick(); tick(); tick(); tick();
        set_mem(1'b1, 32'h1234_5678);
        tick();
        set_mem(1'b0, 32'h0);
        check("race_ready", 64'(bus.m_ready_o), 64'b01);
        check("race_err", 64'(bus.m_err_o), 64'd0);
        check("race_rdata", 64'(bus.m_rdata_o), 64'h1234_5678);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        // Stray ack while idle
        set_mem(1'b1, 32'hFFFF_FFFF);
        tick(); tick(); tick();
        check("stray_state", 64'(state_dbg), 64'(IDLE));
        check("stray_ready", 64'(bus.m_ready_o), 64'd0);
        check("stray_mem_ce", 64'(bus.mem_ce_o), 64'd0);
        check("stray_rdata", 64'(bus.m_rdata_o), 64'h1234_5678);
        set_mem(1'b0, 32'h0);

        // Master drops ce while BUSY: memory cycle completes, no ready pulse
        set_req(0, 1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        check("drop_mem_ce", 64'(bus.mem_ce_o), 64'd1);
        check("drop_mem_addr", 64'(bus.mem_addr_o), 64'h200);
        set_mem(1'b1, 32'hAAAA_5555);
        tick();
        set_mem(1'b0, 32'h0);
        check("drop_state", 64'(state_dbg), 64'(RESP));
        check("drop_ready", 64'(bus.m_ready_o), 64'd0);
        check("drop_rdata", 64'(bus.m_rdata_o), 64'hAAAA_5555);
        tick();
        check("drop_idle", 64'(state_dbg), 64'(IDLE));

        // Reset in the second BUSY cycle, then the held request reruns
        set_req(0, 1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_state", 64'(state_dbg), 64'(IDLE));
        check("mrst_mem_ce", 64'(bus.mem_ce_o), 64'd0);
        check("mrst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
        check("mrst_ready", 64'(bus.m_ready_o), 64'd0);
        check("mrst_rdata", 64'(bus.m_rdata_o), 64'd0);
        check("mrst_err", 64'(bus.m_err_o), 64'd0);
        tick();
        check("mrst_re_addr", 64'(bus.mem_addr_o), 64'h300);
        set_mem(1'b1, 32'h0BAD_F00D);
        tick();
        set_mem(1'b0, 32'h0);
        check("mrst_re_ready", 64'(bus.m_ready_o), 64'b01);
        check("mrst_re_rdata", 64'(bus.m_rdata_o), 64'h0BAD_F00D);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        // Contention from a clean reset: both masters request continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0);
        set_mem(1'b1, 32'h0000_0011);
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.m_ready_o != '0) got_q.push_back(bus.m_ready_o);
        end
        set_mem(1'b0, 32'h0);
        set_req(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        check("cont_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            logic [NM-1:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            check("cont_grant", 64'(g), 64'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
